// File: rtl/dm_bus_arbiter_if.sv
// Request/grant/response data bus bundle shared by the core port, the debug
// module system-bus port and the slave interconnect port of dm_bus_arbiter.
interface dm_bus_arbiter_if;
  logic        req;
  logic        gnt;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  // Side that issues requests and consumes responses.
  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  // Side that accepts requests and produces responses.
  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/dm_bus_arbiter.sv
// Two-master (core, debug) to one-slave arbiter on the req/gnt/rvalid bus.
// Debug has fixed priority; a request left waiting for grant locks the
// selection so slave-side fields stay stable. A small ordered ID FIFO
// remembers which master owns each outstanding transaction so in-order
// responses are routed back without added latency.
module dm_bus_arbiter #(
  parameter int unsigned OUTSTANDING_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  dm_bus_arbiter_if.slave   core,
  dm_bus_arbiter_if.slave   dbg,
  dm_bus_arbiter_if.master  s
);
  localparam int unsigned CNT_W = $clog2(OUTSTANDING_DEPTH + 1);
  localparam int unsigned PTR_W = (OUTSTANDING_DEPTH > 1) ? $clog2(OUTSTANDING_DEPTH) : 1;

  logic [OUTSTANDING_DEPTH-1:0] id_fifo_q;
  logic [PTR_W-1:0]             wr_ptr_q;
  logic [PTR_W-1:0]             rd_ptr_q;
  logic [CNT_W-1:0]             count_q;
  logic                         lock_q;
  logic                         lock_sel_q;

  logic sel_dbg;
  logic sel_req;
  logic full;
  logic empty;
  logic accept;
  logic pop;
  logic head_dbg;

  assign full  = (count_q == CNT_W'(OUTSTANDING_DEPTH));
  assign empty = (count_q == '0);

  // Request selection, slave request/field mux and grant routing.
  always_comb begin
    sel_dbg = lock_q ? lock_sel_q : dbg.req;
    sel_req = sel_dbg ? dbg.req : core.req;

    s.req   = sel_req && !full && !rst_i;
    s.we    = sel_dbg ? dbg.we    : core.we;
    s.be    = sel_dbg ? dbg.be    : core.be;
    s.addr  = sel_dbg ? dbg.addr  : core.addr;
    s.wdata = sel_dbg ? dbg.wdata : core.wdata;

    accept   = s.req && s.gnt;
    core.gnt = accept && !sel_dbg;
    dbg.gnt  = accept &&  sel_dbg;
  end

  // Response routing by the owner at the FIFO head; empty-FIFO responses vanish.
  always_comb begin
    head_dbg    = id_fifo_q[rd_ptr_q];
    pop         = s.rvalid && !empty && !rst_i;
    core.rvalid = pop && !head_dbg;
    dbg.rvalid  = pop &&  head_dbg;
    core.rdata  = s.rdata;
    dbg.rdata   = s.rdata;
    core.err    = s.err && core.rvalid;
    dbg.err     = s.err && dbg.rvalid;
  end

  // Selection lock: hold the chosen master from an ungranted request until its grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q     <= 1'b0;
      lock_sel_q <= 1'b0;
    end else if (accept) begin
      lock_q     <= 1'b0;
    end else if (s.req) begin
      lock_q     <= 1'b1;
      lock_sel_q <= sel_dbg;
    end
  end

  // Ordered ID FIFO: push owner on accept, pop on a response; count tracks occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (accept) begin
        id_fifo_q[wr_ptr_q] <= sel_dbg;
        wr_ptr_q <= (wr_ptr_q == PTR_W'(OUTSTANDING_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_W'(OUTSTANDING_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      if (accept && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !accept) begin
        count_q <= count_q - 1'b1;
      end
    end
  end
endmodule
